// File: rtl/ibex_icache_inval_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ibex_icache_inval_ctrl: sequences icache invalidation (scramble key fetch,
// then a full tag clear) and arbitrates the tag RAM port. Rev 1.0
// ----------------------------------------------------------------------------
module ibex_icache_inval_ctrl #(
  parameter int unsigned            NumWays    = 2,
  parameter int unsigned            IndexW     = 6,
  parameter int unsigned            TagSizeECC = 22,
  parameter logic [TagSizeECC-1:0]  InvalTag   = '0,
  parameter bit                     ScrKeyEn   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   inval_i,
  input  logic [NumWays-1:0]     lk_tag_req_i,
  input  logic                   lk_tag_write_i,
  input  logic [IndexW-1:0]      lk_tag_addr_i,
  input  logic [TagSizeECC-1:0]  lk_tag_wdata_i,
  output logic                   lk_gnt_o,
  output logic [NumWays-1:0]     ic_tag_req_o,
  output logic                   ic_tag_write_o,
  output logic [IndexW-1:0]      ic_tag_addr_o,
  output logic [TagSizeECC-1:0]  ic_tag_wdata_o,
  output logic                   scr_key_req_o,
  input  logic                   scr_key_valid_i,
  output logic                   busy_o,
  output logic                   inval_done_o
);

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_KEY_REQ  = 3'd1;
  localparam logic [2:0] ST_KEY_WAIT = 3'd2;
  localparam logic [2:0] ST_CLEAR    = 3'd3;
  localparam logic [2:0] ST_IDLE     = 3'd4;

  // Entry point of every invalidation sequence depends on key support.
  localparam logic [2:0] ST_START = ScrKeyEn ? ST_KEY_REQ : ST_CLEAR;

  localparam logic [IndexW-1:0] CNT_MAX = '1;

  logic [2:0]        state_q, state_d;
  logic [IndexW-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              clear_last;
  logic              resequence;

  assign clear_last = (cnt_q == CNT_MAX);
  assign resequence = pend_q | inval_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_START;
      end
      ST_KEY_REQ: begin
        if (!scr_key_valid_i) begin
          state_d = ST_KEY_WAIT;
        end
      end
      ST_KEY_WAIT: begin
        if (scr_key_valid_i) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (clear_last) begin
          cnt_d  = '0;
          pend_d = 1'b0;
          if (resequence) begin
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          pend_d = resequence;
        end
      end
      ST_IDLE: begin
        if (inval_i) begin
          state_d = ST_START;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  // Lookup is passed through combinationally only while idle and not being
  // pre-empted by a new invalidation request in the same cycle.
  always_comb begin
    lk_gnt_o       = 1'b0;
    ic_tag_req_o   = '0;
    ic_tag_write_o = 1'b0;
    ic_tag_addr_o  = '0;
    ic_tag_wdata_o = '0;
    scr_key_req_o  = 1'b0;
    busy_o         = 1'b1;
    case (state_q)
      ST_KEY_REQ: begin
        scr_key_req_o = 1'b1;
      end
      ST_CLEAR: begin
        ic_tag_req_o   = '1;
        ic_tag_write_o = 1'b1;
        ic_tag_addr_o  = cnt_q;
        ic_tag_wdata_o = InvalTag;
      end
      ST_IDLE: begin
        busy_o   = 1'b0;
        lk_gnt_o = ~inval_i;
        if (!inval_i) begin
          ic_tag_req_o   = lk_tag_req_i;
          ic_tag_write_o = lk_tag_write_i;
          ic_tag_addr_o  = lk_tag_addr_i;
          ic_tag_wdata_o = lk_tag_wdata_i;
        end
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  assign inval_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_icache_inval_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ibex_icache_inval_ctrl: directed bench with a scoreboard of clear writes.
// ----------------------------------------------------------------------------
module tb_ibex_icache_inval_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inval;
  logic        inval2;
  logic [1:0]  lk_req;
  logic        lk_write;
  logic [5:0]  lk_addr;
  logic [21:0] lk_wdata;
  logic        key_valid;

  logic        gnt, wr, key_req, busy, done;
  logic [1:0]  req;
  logic [5:0]  addr;
  logic [21:0] wdata;

  logic        gnt2, wr2, key_req2, busy2, done2;
  logic [1:0]  req2;
  logic [5:0]  addr2;
  logic [21:0] wdata2;

  int errors = 0;
  int checks = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  ibex_icache_inval_ctrl dut (
    .clk_i(clk), .rst_i(rst), .inval_i(inval),
    .lk_tag_req_i(lk_req), .lk_tag_write_i(lk_write),
    .lk_tag_addr_i(lk_addr), .lk_tag_wdata_i(lk_wdata),
    .lk_gnt_o(gnt), .ic_tag_req_o(req), .ic_tag_write_o(wr),
    .ic_tag_addr_o(addr), .ic_tag_wdata_o(wdata),
    .scr_key_req_o(key_req), .scr_key_valid_i(key_valid),
    .busy_o(busy), .inval_done_o(done)
  );

  ibex_icache_inval_ctrl #(.ScrKeyEn(1'b0)) dut_nokey (
    .clk_i(clk), .rst_i(rst), .inval_i(inval2),
    .lk_tag_req_i(lk_req), .lk_tag_write_i(lk_write),
    .lk_tag_addr_i(lk_addr), .lk_tag_wdata_i(lk_wdata),
    .lk_gnt_o(gnt2), .ic_tag_req_o(req2), .ic_tag_write_o(wr2),
    .ic_tag_addr_o(addr2), .ic_tag_wdata_o(wdata2),
    .scr_key_req_o(key_req2), .scr_key_valid_i(key_valid),
    .busy_o(busy2), .inval_done_o(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_init(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_outs"}, {26'd0, gnt, req, wr, key_req, done}, 32'd0);
    chk({tag, "_addr"}, {26'd0, addr}, 32'd0);
    chk({tag, "_wdata"}, {10'd0, wdata}, 32'd0);
  endtask

  // Entered in KEY_REQ; leaves the DUT in the first CLEAR cycle.
  task automatic key_handshake(input string tag);
    key_valid = 1'b1;
    #1;
    chk({tag, "_keyreq_hold"}, {31'd0, key_req}, 32'd1);
    tick();
    chk({tag, "_keyreq_stay"}, {31'd0, key_req}, 32'd1);
    key_valid = 1'b0;
    tick();
    chk({tag, "_keywait_req"}, {30'd0, key_req, wr}, 32'd0);
    chk({tag, "_keywait_busy"}, {31'd0, busy}, 32'd1);
    tick();
    tick();
    chk({tag, "_keywait_still"}, {30'd0, key_req, wr}, 32'd0);
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  // Runs the 64-index clear; pulses inval at indices p1/p2 and asserts reset
  // at index abort_at (negative values disable).
  task automatic do_clear(input string tag, input int p1, input int p2, input int abort_at);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(i);
    lk_req  = 2'b11;
    lk_addr = 6'h2A;
    for (int i = 0; i < 64; i++) begin
      int unsigned e;
      e = exp_q.pop_front();
      inval = (i == p1) || (i == p2);
      #1;
      chk({tag, "_addr"}, {26'd0, addr}, e);
      if (i == 0 || i == 63 || i == p1 || i == abort_at) begin
        chk({tag, "_ctl"}, {27'd0, req, wr, gnt, busy}, {27'd0, 2'b11, 1'b1, 1'b0, 1'b1});
        chk({tag, "_wdata"}, {10'd0, wdata}, 32'd0);
      end
      if (i == abort_at) begin
        rst = 1'b1;
        tick();
        inval = 1'b0;
        rst   = 1'b0;
        #1;
        chk_init({tag, "_abort"});
        lk_req = 2'b00;
        return;
      end
      tick();
      inval = 1'b0;
    end
    lk_req = 2'b00;
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd2);
    tick();
    chk({tag, "_done_once"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; inval = 1'b0; inval2 = 1'b0;
    lk_req = '0; lk_write = 1'b0; lk_addr = '0; lk_wdata = '0;
    key_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_init("reset");

    rst = 1'b0;
    tick();
    key_handshake("boot");
    do_clear("boot_clear", -1, -1, -1);
    chk_done("boot");

    lk_req = 2'b01; lk_addr = 6'h15; lk_write = 1'b0; lk_wdata = 22'h2BEEF;
    #1;
    chk("idle_gnt", {31'd0, gnt}, 32'd1);
    chk("idle_pass", {24'd0, req, wr, addr}, {24'd0, 2'b01, 1'b0, 6'h15});
    chk("idle_wdata", {10'd0, wdata}, 32'h2BEEF);
    lk_req = 2'b10; lk_addr = 6'h3C; lk_write = 1'b1; lk_wdata = 22'h15A5A;
    #1;
    chk("idle_pass_wr", {24'd0, req, wr, addr}, {24'd0, 2'b10, 1'b1, 6'h3C});
    chk("idle_wdata_wr", {10'd0, wdata}, 32'h15A5A);

    lk_req = 2'b11; lk_write = 1'b0; inval = 1'b1;
    #1;
    chk("inval_gnt", {29'd0, gnt, req}, 32'd0);
    chk("inval_wr", {31'd0, wr}, 32'd0);
    tick();
    inval = 1'b0; lk_req = 2'b00;
    #1;
    chk("inval_keyreq", {30'd0, busy, key_req}, 32'd3);

    key_handshake("pend");
    do_clear("pend_clear", 10, 40, -1);
    #1;
    chk("pend_reseq", {29'd0, busy, key_req, done}, 32'd6);
    key_handshake("pend2");
    do_clear("pend2_clear", -1, -1, -1);
    chk_done("pend2");

    inval = 1'b1;
    tick();
    inval = 1'b0;
    key_handshake("abort");
    do_clear("abort_clear", -1, -1, 30);
    tick();
    chk("abort_keyreq", {31'd0, key_req}, 32'd1);
    key_handshake("abort2");
    do_clear("abort2_clear", -1, -1, -1);
    chk_done("abort2");

    chk("nokey_idle", {31'd0, busy2}, 32'd0);
    inval2 = 1'b1;
    tick();
    inval2 = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(i);
    for (int i = 0; i < 64; i++) begin
      int unsigned e;
      e = exp_q.pop_front();
      chk("nokey_addr", {26'd0, addr2}, e);
      chk("nokey_ctl", {28'd0, key_req2, req2, wr2}, 32'd7);
      tick();
    end
    chk("nokey_done", {29'd0, done2, busy2, key_req2}, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ibex_icache_inval_ctrl.md
Name: ibex_icache_inval_ctrl

Overview:
- Sequences instruction-cache invalidation and owns the cache tag RAM port.
- After reset, or on an invalidation request, it obtains a fresh scramble key and then writes the invalid pattern to every tag index across all ways.
- Outside an invalidation it grants the tag RAM port to the cache lookup logic and passes that logic's requests straight through.
- It sits between the icache body and the tag RAM banks.

Parameters:
- NumWays, 2, number of tag RAM ways.
- IndexW, 6, tag index width; 2**IndexW sets.
- TagSizeECC, 22, tag word width including ECC bits.
- InvalTag, '0 (TagSizeECC bits), word written during clear; valid bit 0, ECC-consistent.
- ScrKeyEn, 1'b1, 1 = fetch a scramble key before clearing; 0 = skip the key states.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- inval_i  in  1  invalidation request; single-cycle pulse or level
- lk_tag_req_i  in  NumWays  lookup per-way tag request
- lk_tag_write_i  in  1  lookup tag write
- lk_tag_addr_i  in  IndexW  lookup tag index
- lk_tag_wdata_i  in  TagSizeECC  lookup tag write data
- lk_gnt_o  out  1  lookup owns the tag port this cycle
- ic_tag_req_o  out  NumWays  tag RAM per-way request
- ic_tag_write_o  out  1  tag RAM write enable
- ic_tag_addr_o  out  IndexW  tag RAM index
- ic_tag_wdata_o  out  TagSizeECC  tag RAM write data
- scr_key_req_o  out  1  scramble key request
- scr_key_valid_i  in  1  scramble key valid
- busy_o  out  1  invalidation in progress
- inval_done_o  out  1  one-cycle pulse when a clear completes

Behaviour:
- Decided: one clock, clk_i; reset rst_i is synchronous and active-high. All state is updated only on the rising edge of clk_i.
- FSM states: INIT, KEY_REQ, KEY_WAIT, CLEAR, IDLE.
- Reset state is INIT, with cnt=0 and pend=0. Output values in reset/INIT: busy_o=1; every other output is 0.
- INIT -> KEY_REQ on the next cycle, or -> CLEAR if ScrKeyEn=0. Every reset therefore performs a full invalidation.
- KEY_REQ:
  - scr_key_req_o=1.
  - Stays in KEY_REQ until scr_key_valid_i=0 is sampled (old key dropped), then -> KEY_WAIT.
- KEY_WAIT:
  - scr_key_req_o=0.
  - -> CLEAR on the first cycle scr_key_valid_i=1.
  - No timeout.
- CLEAR, each cycle:
  - ic_tag_req_o = all ones.
  - ic_tag_write_o=1.
  - ic_tag_addr_o=cnt.
  - ic_tag_wdata_o=InvalTag.
  - cnt increments by 1.
- CLEAR exit: on the cycle cnt == 2**IndexW-1, cnt wraps to 0.
  - If pend=1 -> KEY_REQ (or restart CLEAR at index 0 if ScrKeyEn=0), and pend clears.
  - Otherwise -> IDLE, and inval_done_o=1 in the first IDLE cycle.
- Clear length is exactly 2**IndexW cycles, one index per cycle.
- IDLE:
  - busy_o=0.
  - lk_gnt_o = ~inval_i.
  - When granted, ic_tag_* = lk_tag_* combinationally (zero added latency).
  - When not granted, ic_tag_req_o=0 and ic_tag_write_o=0.
  - inval_i=1 -> KEY_REQ next cycle (CLEAR if ScrKeyEn=0).
- Tag port ownership: busy_o = (state != IDLE); lk_gnt_o=0 whenever busy_o=1. Lookup requests while not granted are ignored, and the requester retries.
- inval_i in KEY_REQ or KEY_WAIT: absorbed with no effect, because a full clear still follows.
- inval_i in CLEAR: sets pend, and one complete re-sequence follows. Any number of further pulses still produce only one re-sequence.
- inval_i in INIT: ignored.
- rst_i during any state: the sequence aborts and returns to INIT. rst_i has priority over inval_i in the same cycle.
- scr_key_valid_i is ignored outside KEY_REQ/KEY_WAIT.

Test Plan:
- Reset release, scr_key_valid_i=1 -> scr_key_req_o stays 1. Drop valid to 0: the FSM moves to KEY_WAIT. Raise valid 3 cycles later: exactly 64 write cycles follow with addr 0..63, req=2'b11, wdata=0. Then inval_done_o pulses once and busy_o falls in the same cycle.
- IDLE, lookup drives req=2'b01, addr=6'h15, write=0 -> ic_tag_* match lk_tag_* in the same cycle, with lk_gnt_o=1.
- IDLE, inval_i together with a lookup req -> lk_gnt_o=0 and ic_tag_req_o=0 that cycle. Next cycle state is KEY_REQ with busy_o=1.
- inval_i pulsed twice in CLEAR at cnt=10 and cnt=40 -> after index 63 the FSM returns to KEY_REQ once. A second 64-cycle clear follows, then a single inval_done_o pulse.
- rst_i asserted mid-CLEAR at cnt=30 -> the next cycle is INIT with all outputs 0 and busy_o=1. A full key + 64-index clear restarts from index 0.
- ScrKeyEn=0, inval_i in IDLE -> scr_key_req_o is never asserted. The CLEAR writes start the next cycle and run 64 cycles.
